// File: rtl/vram_l1_cache.sv
// rtl/vram_l1_cache.sv - direct-mapped write-back L1 cache for byte accesses to VRAM
module vram_l1_cache #(
  parameter int L1_DEPTH      = 64,
  parameter int L1_WIDTH      = 64,
  parameter int FB_ADDR_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [16:0]              core_addr,
  input  logic [7:0]               core_wdata,
  output logic                     core_ack,
  output logic [7:0]               core_rdata,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [FB_ADDR_WIDTH-1:0] mem_addr,
  output logic [L1_WIDTH-1:0]      mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [L1_WIDTH-1:0]      mem_rdata
);

  // The address split and the line geometry are hard-wired to these sizes.
  generate
    if (L1_DEPTH != 64 || L1_WIDTH != 64 || FB_ADDR_WIDTH != 14) begin : g_bad_param
      $error("vram_l1_cache supports only L1_DEPTH=64, L1_WIDTH=64, FB_ADDR_WIDTH=14");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [16:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [63:0]      valid_q, valid_d;
  logic [63:0]      dirty_q, dirty_d;
  logic [63:0][7:0] tag_q, tag_d;
  logic [6:0]       scan_q, scan_d;          // bit 6 set means all 64 lines scanned
  logic             flush_pending_q, flush_pending_d;
  logic             flush_done_q, flush_done_d;

  logic [63:0]      data_q [64];
  logic             data_we;
  logic [5:0]       data_widx;
  logic [63:0]      data_wline;

  logic [7:0]       lk_tag;
  logic [5:0]       lk_idx;
  logic [2:0]       lk_off;
  logic [5:0]       sel_idx;
  logic [63:0]      line_sel;
  logic             hit;
  logic             in_flush;

  assign lk_tag   = addr_q[16:9];
  assign lk_idx   = addr_q[8:3];
  assign lk_off   = addr_q[2:0];
  assign in_flush = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  assign sel_idx  = in_flush ? scan_q[5:0] : lk_idx;
  assign line_sel = data_q[sel_idx];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign core_ack   = (state_q == S_RESP);
  assign core_rdata = rdata_q;
  assign flush_done = flush_done_q;

  // Next-state, downstream handshake and array-update decisions.
  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    tag_d           = tag_q;
    scan_d          = scan_q;
    flush_pending_d = flush_pending_q | (flush && (state_q != S_IDLE));
    flush_done_d    = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    data_we         = 1'b0;
    data_widx       = lk_idx;
    data_wline      = line_sel;

    case (state_q)
      S_IDLE: begin
        if (flush || flush_pending_q) begin
          state_d = S_FLUSH_SCAN;
          scan_d  = '0;
        end else if (core_req) begin
          we_d    = core_we;
          addr_d  = core_addr;
          wdata_d = core_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (we_q) begin
            data_we                           = 1'b1;
            data_wline[{lk_off, 3'b000} +: 8] = wdata_q;
            dirty_d[lk_idx]                   = 1'b1;
          end else begin
            rdata_d = line_sel[{lk_off, 3'b000} +: 8];
          end
          state_d = S_RESP;
        end else if (valid_q[lk_idx] && dirty_q[lk_idx]) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL_REQ;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[lk_idx], lk_idx};
        mem_wdata = line_sel;
        if (mem_gnt) begin
          dirty_d[lk_idx] = 1'b0;
          state_d         = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {lk_tag, lk_idx};
        if (mem_gnt) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          data_we    = 1'b1;
          data_wline = mem_rdata;
          if (we_q) data_wline[{lk_off, 3'b000} +: 8] = wdata_q;
          valid_d[lk_idx] = 1'b1;
          tag_d[lk_idx]   = lk_tag;
          dirty_d[lk_idx] = we_q;
          rdata_d         = mem_rdata[{lk_off, 3'b000} +: 8];
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (scan_q[6]) begin
          flush_done_d    = 1'b1;
          flush_pending_d = 1'b0;
          state_d         = S_IDLE;
        end else if (valid_q[scan_q[5:0]] && dirty_q[scan_q[5:0]]) begin
          state_d = S_FLUSH_WB;
        end else begin
          scan_d = scan_q + 7'd1;
        end
      end
      S_FLUSH_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[scan_q[5:0]], scan_q[5:0]};
        mem_wdata = line_sel;
        if (mem_gnt) begin
          dirty_d[scan_q[5:0]] = 1'b0;
          scan_d               = scan_q + 7'd1;
          state_d              = S_FLUSH_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, tags and line status; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
      tag_q           <= '0;
      scan_q          <= '0;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      tag_q           <= tag_d;
      scan_q          <= scan_d;
      flush_pending_q <= flush_pending_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // Line data array; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_widx] <= data_wline;
  end

endmodule

// File: tb/tb_vram_l1_cache.sv
// tb/tb_vram_l1_cache.sv - directed self-checking bench for vram_l1_cache
module tb_vram_l1_cache;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [16:0] core_addr;
  logic [7:0]  core_wdata;
  logic        core_ack;
  logic [7:0]  core_rdata;
  logic        flush;
  logic        flush_done;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  vram_l1_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Downstream memory model: fill word a returns bytes (8a+k) unless written back.
  logic [63:0] wb_mem [logic [13:0]];
  logic        log_we    [$];
  logic [13:0] log_addr  [$];
  logic [63:0] log_wdata [$];
  int          gnt_delay = 0;
  logic        hold_fill = 1'b0;
  logic        pend_fill = 1'b0;
  logic [13:0] pend_addr;

  function automatic logic [63:0] model_line(input logic [13:0] a);
    logic [63:0] l;
    if (wb_mem.exists(a)) return wb_mem[a];
    for (int k = 0; k < 8; k++) l[8*k +: 8] = 8'(32'(a) * 8 + k);
    return l;
  endfunction

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_wdata.delete();
  endtask

  initial begin
    int          wait_cnt;
    logic        cap_we;
    logic [13:0] cap_addr;
    logic [63:0] cap_wdata;
    wait_cnt   = 0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend_fill && !hold_fill && rst_n) begin
        mem_rvalid = 1'b1;
        mem_rdata  = model_line(pend_addr);
        pend_fill  = 1'b0;
      end else if (mem_req && rst_n) begin
        if (wait_cnt == 0) begin
          cap_we    = mem_we;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
        end else begin
          check("hold_we", 64'(mem_we), 64'(cap_we));
          check("hold_addr", 64'(mem_addr), 64'(cap_addr));
          check("hold_wdata", mem_wdata, cap_wdata);
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          log_we.push_back(mem_we);
          log_addr.push_back(mem_addr);
          log_wdata.push_back(mem_wdata);
          if (mem_we) wb_mem[mem_addr] = mem_wdata;
          else begin
            pend_fill = 1'b1;
            pend_addr = mem_addr;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_access(input logic we, input logic [16:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat);
    @(negedge clk);
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wd;
    lat        = 0;
    rd         = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (core_ack) begin
        lat = i;
        rd  = core_rdata;
        break;
      end
    end
    core_req = 1'b0;
    if (lat == 0) check("ack_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    int         pulses;
    logic       done_seen;
    logic       ack_seen;

    rst_n      = 1'b0;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_ack", 64'(core_ack), 64'd0);
    check("rst_core_rdata", 64'(core_rdata), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;

    // Cold load miss, then the same load hits.
    clear_log();
    do_access(1'b0, 17'h00005, 8'h00, rd, lat);
    check("t1_fill_cnt", 64'(log_addr.size()), 64'd1);
    check("t1_fill_addr", 64'(log_addr[0]), 64'h0000);
    check("t1_fill_we", 64'(log_we[0]), 64'd0);
    check("t1_rdata", 64'(rd), 64'h05);
    clear_log();
    do_access(1'b0, 17'h00005, 8'h00, rd, lat);
    check("t1_hit_lat", 64'(lat), 64'd2);
    check("t1_hit_rdata", 64'(rd), 64'h05);
    check("t1_hit_nomem", 64'(log_addr.size()), 64'd0);

    // Store miss allocates and dirties, load then hits.
    clear_log();
    do_access(1'b1, 17'h00009, 8'hAA, rd, lat);
    check("t2_fill_cnt", 64'(log_addr.size()), 64'd1);
    check("t2_fill_addr", 64'(log_addr[0]), 64'h0001);
    clear_log();
    do_access(1'b0, 17'h00009, 8'h00, rd, lat);
    check("t2_hit_lat", 64'(lat), 64'd2);
    check("t2_rdata", 64'(rd), 64'hAA);
    check("t2_nomem", 64'(log_addr.size()), 64'd0);
    check("t2_dirty1", 64'(dut.dirty_q[1]), 64'd1);

    // Conflict miss on dirty idx 1 with a slow grant.
    clear_log();
    gnt_delay = 5;
    do_access(1'b0, 17'h00209, 8'h00, rd, lat);
    gnt_delay = 0;
    check("t3_txn_cnt", 64'(log_addr.size()), 64'd2);
    check("t3_wb_we", 64'(log_we[0]), 64'd1);
    check("t3_wb_addr", 64'(log_addr[0]), 64'h0001);
    check("t3_wb_data", log_wdata[0], 64'h0F0E0D0C0B0AAA08);
    check("t3_fill_we", 64'(log_we[1]), 64'd0);
    check("t3_fill_addr", 64'(log_addr[1]), 64'h0041);
    check("t3_rdata", 64'(rd), 64'h09);

    // Flush with dirty lines at idx 3 and idx 63.
    do_access(1'b1, 17'h00018, 8'h55, rd, lat);
    do_access(1'b1, 17'h005FF, 8'h66, rd, lat);
    clear_log();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      if (flush_done) pulses++;
      @(negedge clk);
    end
    check("t4_done_pulses", 64'(pulses), 64'd1);
    check("t4_wb_cnt", 64'(log_addr.size()), 64'd2);
    check("t4_wb0_addr", 64'(log_addr[0]), 64'h0003);
    check("t4_wb0_data", log_wdata[0], 64'h1F1E1D1C1B1A1955);
    check("t4_wb1_addr", 64'(log_addr[1]), 64'h00BF);
    check("t4_wb1_data", log_wdata[1], 64'h66FEFDFCFBFAF9F8);
    check("t4_dirty3", 64'(dut.dirty_q[3]), 64'd0);
    check("t4_dirty63", 64'(dut.dirty_q[63]), 64'd0);
    clear_log();
    do_access(1'b0, 17'h00018, 8'h00, rd, lat);
    check("t4_hit3_lat", 64'(lat), 64'd2);
    check("t4_hit3_rdata", 64'(rd), 64'h55);
    do_access(1'b0, 17'h005FF, 8'h00, rd, lat);
    check("t4_hit63_lat", 64'(lat), 64'd2);
    check("t4_hit63_rdata", 64'(rd), 64'h66);
    check("t4_nomem", 64'(log_addr.size()), 64'd0);

    // Flush and core request in the same IDLE cycle.
    do_access(1'b1, 17'h00019, 8'h77, rd, lat);
    clear_log();
    @(negedge clk);
    flush     = 1'b1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 17'h00019;
    done_seen = 1'b0;
    ack_seen  = 1'b0;
    rd        = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (flush_done) done_seen = 1'b1;
      if (core_ack) begin
        ack_seen = 1'b1;
        rd       = core_rdata;
        break;
      end
    end
    core_req = 1'b0;
    check("t5_ack_seen", 64'(ack_seen), 64'd1);
    check("t5_done_first", 64'(done_seen), 64'd1);
    check("t5_rdata", 64'(rd), 64'h77);
    check("t5_wb_cnt", 64'(log_addr.size()), 64'd1);
    check("t5_wb_data", log_wdata[0], 64'h1F1E1D1C1B1A7755);

    // Reset while waiting for fill data.
    clear_log();
    hold_fill = 1'b1;
    @(negedge clk);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 17'h00020;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (log_addr.size() != 0) break;
    end
    check("t6_fill_issued", 64'(log_addr.size()), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req", 64'(mem_req), 64'd0);
    check("t6_rst_core_ack", 64'(core_ack), 64'd0);
    check("t6_rst_rdata", 64'(core_rdata), 64'd0);
    core_req  = 1'b0;
    pend_fill = 1'b0;
    hold_fill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    do_access(1'b0, 17'h00005, 8'h00, rd, lat);
    check("t6_miss_cnt", 64'(log_addr.size()), 64'd1);
    check("t6_miss_addr", 64'(log_addr[0]), 64'h0000);
    check("t6_rdata", 64'(rd), 64'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
